// File: rtl/jacobi_rot_fifo.sv
// Show-ahead multi-lane FIFO that buffers rotation CORDIC x/y/z results for the Jacobi controller.
// Adds a registered almost-full flag, a sticky overflow flag and a synchronous flush.
module jacobi_rot_fifo #(
    parameter int unsigned JACOBI_OUTPUT_WORD_WIDTH = 16,
    parameter int unsigned WIDTH                    = JACOBI_OUTPUT_WORD_WIDTH,
    parameter int unsigned CH                       = 3,
    parameter int unsigned DEPTH                    = 16,
    parameter int unsigned AF_LEVEL                 = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic [CH*WIDTH-1:0]          in_dat_i,
    input  logic                         in_vld_i,
    output logic                         in_rdy_o,
    output logic [CH*WIDTH-1:0]          out_dat_o,
    output logic                         out_vld_o,
    input  logic                         out_rdy_i,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         almost_full_o,
    output logic                         overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] DepthLvl = LW'(DEPTH);
    localparam logic [LW-1:0] AfLvl    = LW'(AF_LEVEL);

    logic [CH*WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                af_q, af_d;
    logic                ovf_q, ovf_d;
    logic                push, pop;

    // A full FIFO still takes a write when the head is popped in the same cycle.
    always_comb begin
        out_vld_o = (level_q != '0);
        pop       = out_vld_o & out_rdy_i;
        in_rdy_o  = (level_q < DepthLvl) | pop;
        push      = in_vld_i & in_rdy_o;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop) begin
                level_d = level_q + LW'(1);
            end else if (!push && pop) begin
                level_d = level_q - LW'(1);
            end
            if (in_vld_i && !in_rdy_o) ovf_d = 1'b1;
        end
        af_d = (level_d >= AfLvl);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; validity is tracked solely by the occupancy counter.
    always_ff @(posedge clk) begin
        if (rst && !flush_i && push) begin
            mem_q[wr_ptr_q] <= in_dat_i;
        end
    end

    assign out_dat_o     = mem_q[rd_ptr_q];
    assign level_o       = level_q;
    assign almost_full_o = af_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_jacobi_rot_fifo.sv
// Randomised scoreboard bench for jacobi_rot_fifo: a queue-based reference model feeds expected
// entries to a monitor that checks data order, level, flags and handshake every cycle.
module tb_jacobi_rot_fifo;

    localparam int unsigned W     = 16;
    localparam int unsigned CH    = 3;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 12;
    localparam int unsigned DW    = CH * W;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_i;
    logic [DW-1:0] in_dat_i;
    logic          in_vld_i;
    logic          in_rdy_o;
    logic [DW-1:0] out_dat_o;
    logic          out_vld_o;
    logic          out_rdy_i;
    logic [LW-1:0] level_o;
    logic          almost_full_o;
    logic          overflow_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] sb_q[$];
    int            m_level = 0;
    bit            m_ovf   = 1'b0;
    bit            m_init  = 1'b0;

    jacobi_rot_fifo #(
        .WIDTH   (W),
        .CH      (CH),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .in_dat_i     (in_dat_i),
        .in_vld_i     (in_vld_i),
        .in_rdy_o     (in_rdy_o),
        .out_dat_o    (out_dat_o),
        .out_vld_o    (out_vld_o),
        .out_rdy_i    (out_rdy_i),
        .level_o      (level_o),
        .almost_full_o(almost_full_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack(input int x, input int y, input int z);
        logic [DW-1:0] d;
        d = '0;
        d[0*W +: W] = W'(x);
        d[1*W +: W] = W'(y);
        d[2*W +: W] = W'(z);
        return d;
    endfunction

    // Reference model: FIFO as a plain queue with a count, updated on each rising edge.
    always @(posedge clk) begin
        bit do_pop, do_push;
        if (!rst) begin
            sb_q.delete();
            m_level = 0;
            m_ovf   = 1'b0;
            m_init  = 1'b1;
        end else if (m_init) begin
            if (flush_i) begin
                sb_q.delete();
                m_level = 0;
            end else begin
                do_pop  = (m_level > 0) && out_rdy_i;
                do_push = in_vld_i && ((m_level < DEPTH) || do_pop);
                if (in_vld_i && !do_push) m_ovf = 1'b1;
                if (do_push) sb_q.push_back(in_dat_i);
                m_level = m_level + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
            end
        end
    end

    // Monitor: compares every output mid-cycle and consumes scoreboard entries on a pop.
    always @(negedge clk) begin
        logic [DW-1:0] exp_dat;
        if (m_init) begin
            check("level", 64'(level_o), 64'(m_level));
            check("out_vld", 64'(out_vld_o), 64'(m_level != 0));
            check("almost_full", 64'(almost_full_o), 64'(m_level >= AF));
            check("overflow", 64'(overflow_o), 64'(m_ovf));
            check("in_rdy", 64'(in_rdy_o),
                  64'((m_level < DEPTH) || ((m_level > 0) && out_rdy_i)));
            if (out_vld_o && out_rdy_i) begin
                if (sb_q.size() == 0) begin
                    check("pop_with_empty_scoreboard", 64'(1), 64'(0));
                end else begin
                    exp_dat = sb_q.pop_front();
                    check("out_dat", 64'(out_dat_o), 64'(exp_dat));
                end
            end
        end
    end

    task automatic step(input bit vld, input logic [DW-1:0] dat, input bit rdy,
                        input bit fl = 1'b0, input bit rn = 1'b1);
        in_vld_i  = vld;
        in_dat_i  = dat;
        out_rdy_i = rdy;
        flush_i   = fl;
        rst       = rn;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd();
        return pack($urandom, $urandom, $urandom);
    endfunction

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
    endtask

    initial begin
        in_vld_i  = 1'b0;
        in_dat_i  = '0;
        out_rdy_i = 1'b0;
        flush_i   = 1'b0;
        rst       = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0);

        // Three entries held, then drained in order.
        step(1'b1, pack(1, 2, 3), 1'b0);
        step(1'b1, pack(4, 5, 6), 1'b0);
        step(1'b1, pack(7, 8, 9), 1'b0);
        check("head_after_3", 64'(out_dat_o), 64'(pack(1, 2, 3)));
        step(1'b0, '0, 1'b0);
        drain(4);

        // Empty FIFO with push and out_rdy: no pop, level becomes 1.
        step(1'b1, rnd(), 1'b1);
        drain(2);

        // Fill to DEPTH, then a dropped write.
        for (int i = 0; i < DEPTH; i++) step(1'b1, rnd(), 1'b0);
        step(1'b1, rnd(), 1'b0);
        step(1'b0, '0, 1'b0);
        check("overflow_sticky", 64'(overflow_o), 64'(1));

        // Full + push + pop: 0xAA enters, emerges 16th.
        step(1'b1, pack(8'hAA, 8'hAA, 8'hAA), 1'b1);
        drain(DEPTH + 2);

        // Sustained push/pop with incrementing data across two pointer wraps.
        step(1'b1, pack(0, 1, 2), 1'b0);
        for (int i = 1; i <= 40; i++) step(1'b1, pack(3 * i, 3 * i + 1, 3 * i + 2), 1'b1);
        drain(2);

        // Flush at level 5 with a concurrent push; overflow must survive.
        for (int i = 0; i < 5; i++) step(1'b1, rnd(), 1'b0);
        step(1'b1, rnd(), 1'b1, 1'b1);
        check("flush_level", 64'(level_o), 64'(0));
        check("flush_keeps_overflow", 64'(overflow_o), 64'(1));
        step(1'b1, pack(8'h11, 8'h22, 8'h33), 1'b0);
        check("post_flush_head", 64'(out_dat_o), 64'(pack(8'h11, 8'h22, 8'h33)));
        drain(2);

        // Reset mid-stream at level 9.
        for (int i = 0; i < 9; i++) step(1'b1, rnd(), 1'b0);
        step(1'b1, rnd(), 1'b1, 1'b1, 1'b0);
        check("rst_level", 64'(level_o), 64'(0));
        check("rst_overflow", 64'(overflow_o), 64'(0));
        step(1'b0, '0, 1'b0);
        check("rst_in_rdy", 64'(in_rdy_o), 64'(1));

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) < 60), rnd(), ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 2), ($urandom_range(0, 299) != 0));
        end
        drain(DEPTH + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jacobi_rot_fifo.md
# jacobi_rot_fifo

Parametrised multi-channel show-ahead FIFO that buffers the rotation CORDIC's x/y/z results before the Jacobi main controller consumes them. The CORDIC pipeline has no backpressure, so this block also provides a programmable almost-full threshold for issue throttling, a sticky overflow flag and a synchronous flush. It sits between `rotation_cordic` outputs and the controller's `rotation_fifo_out_*` inputs inside the Jacobi top level.

## Interface
Parameters:
- `WIDTH`, `JACOBI_OUTPUT_WORD_WIDTH` — bits per channel word.
- `CH`, 3 — channels per entry (x, y, z); lane c occupies bits [c*WIDTH +: WIDTH].
- `DEPTH`, 16 — entries; must be a power of 2, ≥ 4.
- `AF_LEVEL`, 12 — almost-full threshold, 1..DEPTH.

Ports:
- `clk`  in  1  — single clock; all logic on rising edge.
- `rst`  in  1  — synchronous, active-low reset.
- `flush_i`  in  1  — synchronous clear of contents.
- `in_dat_i`  in  CH*WIDTH  — write entry.
- `in_vld_i`  in  1  — write request.
- `in_rdy_o`  out  1  — write will be accepted this cycle.
- `out_dat_o`  out  CH*WIDTH  — head entry (show-ahead).
- `out_vld_o`  out  1  — head entry valid.
- `out_rdy_i`  in  1  — consumer pops head.
- `level_o`  out  $clog2(DEPTH+1)  — current occupancy.
- `almost_full_o`  out  1  — level_o ≥ AF_LEVEL.
- `overflow_o`  out  1  — sticky: a write was dropped.

## Operation
- Storage: DEPTH×(CH*WIDTH) array; write pointer, read pointer ($clog2(DEPTH) bits, natural wrap at DEPTH-1→0) and registered occupancy counter.
- push = in_vld_i & in_rdy_o; pop = out_vld_o & out_rdy_i.
- in_rdy_o = (level_o < DEPTH) | pop (full FIFO accepts a write in the same cycle as a pop). Combinational; no path from in_vld_i to in_rdy_o.
- out_vld_o = (level_o != 0); out_dat_o = array[rd_ptr]; lanes never reordered or mixed between entries.
- Level update: push only +1, pop only −1, both → unchanged (pointers both advance).
- Dropped write: in_vld_i=1 & in_rdy_o=0 → data discarded, overflow_o set next cycle, held until reset (flush does not clear it).
- Flush (flush_i=1, rst=1): pointers and level to 0 next cycle; any same-cycle push/pop ignored; overflow_o retained; no overflow set by the flush cycle itself.
- Reset (rst=0) overrides flush and everything else, including mid-stream; array contents need not be cleared.
- Precedence: rst > flush_i > push/pop.

## Timing
- Reset values: out_vld_o=0, level_o=0, almost_full_o=0, overflow_o=0, in_rdy_o=1 (first cycle after rst returns high); out_dat_o undefined.
- Write latency: entry pushed at edge k appears on out_dat_o with out_vld_o=1 after edge k (visible in cycle k+1); no bypass in the same cycle.
- Empty + push + out_rdy_i=1: no pop (out_vld_o=0); level becomes 1.
- Full + push + pop: both accepted, level stays DEPTH, no overflow.
- almost_full_o and level_o are registered, updated on the same edge as the occupancy change.
- Sustained throughput: one push and one pop per cycle at any level 1..DEPTH.
- out_dat_o stable while out_vld_o=1 and out_rdy_i=0.

## Test plan
- Reset then push 3 entries {x,y,z}={1,2,3},{4,5,6},{7,8,9} with out_rdy_i=0 → level_o=3, out_dat_o={1,2,3}; raise out_rdy_i → entries out in order over 3 cycles, out_vld_o drops after third.
- Fill DEPTH=16 entries → in_rdy_o=0, almost_full_o asserted on the edge level reaches 12; 17th write with no pop → dropped, overflow_o=1 and stays 1 after later flush.
- At level 16, push value 0xAA on all lanes with out_rdy_i=1 → level stays 16, no overflow; 0xAA emerges as 16th output after draining.
- Continuous push/pop for 40 cycles (pointer wrap twice) with incrementing data → output sequence identical, level constant at 1.
- Level 5, assert flush_i with concurrent push → next cycle level_o=0, out_vld_o=0; subsequent push of {0x11,0x22,0x33} is the next output.
- Assert rst=0 mid-stream at level 9 with overflow_o=1 → next cycle all outputs at reset values, in_rdy_o=1 once rst=1.
